// File: rtl/led_pkg.sv
// Shared definitions for the LED output stages: brightness range helper, per-channel
// fade state and default timing constants.
package led_pkg;

  localparam int unsigned DEFAULT_PWM_BITS = 8;
  localparam int unsigned DEFAULT_STEP_DIV = 65536;

  typedef enum logic [1:0] {
    StOff,
    StRise,
    StOn,
    StFall
  } ch_state_e;

  function automatic int unsigned lvl_max(input int unsigned bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: fade FSM with saturating brightness level and registered PWM
// comparator output.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS  = DEFAULT_PWM_BITS,
  parameter int unsigned FADE_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                mode,
  input  logic                step_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                target_bit,
  output logic                led_q,
  output logic                level_ne_target
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(lvl_max(PWM_BITS));
  localparam logic [PWM_BITS:0]   STEP    = (PWM_BITS + 1)'(FADE_STEP);

  ch_state_e           state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS:0]   sum;
  logic [PWM_BITS-1:0] level_up, level_dn;

  assign target = target_bit ? LVL_MAX : '0;

  // One extra bit of headroom so the rising step saturates instead of wrapping.
  assign sum      = {1'b0, level_q} + STEP;
  assign level_up = (sum > {1'b0, LVL_MAX}) ? LVL_MAX : sum[PWM_BITS-1:0];
  assign level_dn = ({1'b0, level_q} < STEP) ? '0 : level_q - STEP[PWM_BITS-1:0];

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (enable) begin
      if (mode) begin
        level_d = target;
        state_d = target_bit ? StOn : StOff;
      end else begin
        unique case (state_q)
          StOff:   state_d = target_bit ? StRise : StOff;
          StRise:  state_d = target_bit ? StRise : StFall;
          StOn:    state_d = target_bit ? StOn   : StFall;
          StFall:  state_d = target_bit ? StRise : StFall;
          default: state_d = StOff;
        endcase
        if (step_tick) begin
          if (state_d == StRise) begin
            level_d = level_up;
          end else if (state_d == StFall) begin
            level_d = level_dn;
          end
        end
        // Settle into the end state on the same edge the level reaches its bound.
        if (state_d == StRise && level_d == LVL_MAX) begin
          state_d = StOn;
        end
        if (state_d == StFall && level_d == '0) begin
          state_d = StOff;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOff;
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q   <= enable && (pwm_cnt < level_q);
    end
  end

  assign level_ne_target = (level_q != target);

endmodule

// File: rtl/led_pwm_fader.sv
// PWM fader between the LED pattern generator and the pads: shared PWM counter and
// fade prescaler, one fading channel per LED, registered busy flag.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = 6,
  parameter int unsigned PWM_BITS  = DEFAULT_PWM_BITS,
  parameter int unsigned STEP_DIV  = DEFAULT_STEP_DIV,
  parameter int unsigned FADE_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                enable,
  input  logic                mode,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int unsigned         PRESC_W    = $clog2(STEP_DIV);
  localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'(lvl_max(PWM_BITS) - 1);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PRESC_W-1:0]  presc_q;
  logic                step_tick;
  logic                busy_q;
  logic [NUM_LEDS-1:0] ne;

  // Gated by enable so a frozen block never sees a pending tick.
  assign step_tick = enable && (presc_q == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      if (enable) begin
        pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        presc_q   <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      end
      busy_q <= |ne;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .mode            (mode),
      .step_tick       (step_tick),
      .pwm_cnt         (pwm_cnt_q),
      .target_bit      (pattern_in[i]),
      .led_q           (led_out[i]),
      .level_ne_target (ne[i])
    );
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: three instances (normal, large step, slow prescaler) checked
// every cycle against an arithmetic reference model plus directed fade sequences.
module tb_led_pwm_fader;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] pattern_in = '0;
  logic       enable = 1'b1;
  logic       mode = 1'b0;
  logic [5:0] led0, led1, led2;
  logic       busy0, busy1, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_pwm_fader #(.NUM_LEDS(6), .PWM_BITS(8), .STEP_DIV(4), .FADE_STEP(64)) dut0 (
    .clk(clk), .rst(rst), .pattern_in(pattern_in), .enable(enable), .mode(mode),
    .led_out(led0), .busy(busy0)
  );
  led_pwm_fader #(.NUM_LEDS(6), .PWM_BITS(8), .STEP_DIV(4), .FADE_STEP(200)) dut1 (
    .clk(clk), .rst(rst), .pattern_in(pattern_in), .enable(enable), .mode(mode),
    .led_out(led1), .busy(busy1)
  );
  led_pwm_fader #(.NUM_LEDS(6), .PWM_BITS(8), .STEP_DIV(1024), .FADE_STEP(64)) dut2 (
    .clk(clk), .rst(rst), .pattern_in(pattern_in), .enable(enable), .mode(mode),
    .led_out(led2), .busy(busy2)
  );

  // Reference model: brightness moves toward the target by STEP on each tick.
  int         steps [3] = '{64, 200, 64};
  int         divs  [3] = '{4, 4, 1024};
  int         m_lvl [3][6];
  int         m_pwm [3];
  int         m_presc [3];
  logic [5:0] m_led [3];
  logic       m_busy [3];

  task automatic model_step();
    int tgt;
    bit tick;
    logic [5:0] led_n;
    logic busy_n;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pwm[i] = 0; m_presc[i] = 0; m_led[i] = '0; m_busy[i] = 1'b0;
        for (int c = 0; c < 6; c++) m_lvl[i][c] = 0;
      end else begin
        tick   = enable && (m_presc[i] == divs[i] - 1);
        led_n  = '0;
        busy_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
          tgt = pattern_in[c] ? 255 : 0;
          led_n[c] = enable && (m_pwm[i] < m_lvl[i][c]);
          if (m_lvl[i][c] != tgt) busy_n = 1'b1;
          if (enable) begin
            if (mode) m_lvl[i][c] = tgt;
            else if (tick && tgt > m_lvl[i][c])
              m_lvl[i][c] = (m_lvl[i][c] + steps[i] > 255) ? 255 : m_lvl[i][c] + steps[i];
            else if (tick && tgt < m_lvl[i][c])
              m_lvl[i][c] = (m_lvl[i][c] < steps[i]) ? 0 : m_lvl[i][c] - steps[i];
          end
        end
        m_led[i]  = led_n;
        m_busy[i] = busy_n;
        if (enable) begin
          m_pwm[i]   = (m_pwm[i] + 1) % 255;
          m_presc[i] = (m_presc[i] + 1) % divs[i];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic int get_led(input int i);
    case (i)
      0:       return int'(led0);
      1:       return int'(led1);
      default: return int'(led2);
    endcase
  endfunction

  function automatic int get_busy(input int i);
    case (i)
      0:       return int'(busy0);
      1:       return int'(busy1);
      default: return int'(busy2);
    endcase
  endfunction

  function automatic int get_lvl0(input int i);
    case (i)
      0:       return int'(dut0.g_ch[0].u_ch.level_q);
      1:       return int'(dut1.g_ch[0].u_ch.level_q);
      default: return int'(dut2.g_ch[0].u_ch.level_q);
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        check("led_out", i, get_led(i), int'(m_led[i]));
        check("busy", i, get_busy(i), int'(m_busy[i]));
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_change(input int inst, input int old, input int budget, output int v);
    v = old;
    for (int k = 0; k < budget && v == old; k++) begin
      tick_n(1);
      v = get_lvl0(inst);
    end
    if (v == old) begin
      n_checks++;
      n_fail++;
      $display("FAIL level_timeout[%0d]: level stuck at %0d after %0d cycles", inst, v, budget);
    end
  endtask

  task automatic snap_off();
    mode = 1'b1;
    pattern_in = '0;
    tick_n(2);
    mode = 1'b0;
  endtask

  typedef struct {
    logic [5:0] pat;
    logic       mode;
    logic       en;
    int         cyc;
    logic [5:0] exp_led;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[8];
  int   rise_exp[4] = '{64, 128, 192, 255};
  int   lvl, sv_lvl, sv_pwm, sv_presc, highs;

  initial begin
    vecs[0] = '{6'h2A, 1'b1, 1'b1, 3, 6'h2A, 1'b0};
    vecs[1] = '{6'h15, 1'b1, 1'b1, 3, 6'h15, 1'b0};
    vecs[2] = '{6'h3F, 1'b1, 1'b1, 3, 6'h3F, 1'b0};
    vecs[3] = '{6'h00, 1'b1, 1'b1, 3, 6'h00, 1'b0};
    vecs[4] = '{6'h2A, 1'b1, 1'b0, 3, 6'h00, 1'b1};
    vecs[5] = '{6'h2A, 1'b1, 1'b1, 3, 6'h2A, 1'b0};
    vecs[6] = '{6'h2A, 1'b0, 1'b1, 3, 6'h2A, 1'b0};
    vecs[7] = '{6'h01, 1'b0, 1'b0, 2, 6'h00, 1'b1};

    #1 rst = 1'b1;
    tick_n(3);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) check("reset_level", i, get_lvl0(i), 0);
    check("reset_pwm", 0, int'(dut0.pwm_cnt_q), 0);
    check("reset_presc", 0, int'(dut0.presc_q), 0);

    // Rise 0 -> full in four ticks; busy drops one cycle after reaching 255.
    pattern_in = 6'b000001;
    for (int k = 0; k < 4; k++) begin
      wait_change(0, (k == 0) ? 0 : rise_exp[k-1], 12, lvl);
      check("rise_level", k, lvl, rise_exp[k]);
    end
    check("rise_busy_hold", 0, int'(busy0), 1);
    check("rise_state_on", 0, int'(dut0.g_ch[0].u_ch.state_q), int'(StOn));
    tick_n(1);
    check("rise_busy_drop", 0, int'(busy0), 0);

    // Reversal mid-fade continues from the current level.
    snap_off();
    pattern_in = 6'b000001;
    wait_change(0, 0, 12, lvl);
    wait_change(0, 64, 12, lvl);
    check("rev_at_128", 0, lvl, 128);
    check("rev_state_rise", 0, int'(dut0.g_ch[0].u_ch.state_q), int'(StRise));
    pattern_in = '0;
    wait_change(0, 128, 12, lvl);
    check("rev_level_64", 0, lvl, 64);
    check("rev_state_fall", 0, int'(dut0.g_ch[0].u_ch.state_q), int'(StFall));
    wait_change(0, 64, 12, lvl);
    check("rev_level_0", 0, lvl, 0);
    check("rev_state_off", 0, int'(dut0.g_ch[0].u_ch.state_q), int'(StOff));

    // Enable freeze at level 128.
    pattern_in = 6'b000001;
    wait_change(0, 0, 12, lvl);
    wait_change(0, 64, 12, lvl);
    enable   = 1'b0;
    sv_lvl   = get_lvl0(0);
    sv_pwm   = int'(dut0.pwm_cnt_q);
    sv_presc = int'(dut0.presc_q);
    tick_n(100);
    check("freeze_led", 0, int'(led0), 0);
    check("freeze_level", 0, get_lvl0(0), 128);
    check("freeze_pwm", 0, int'(dut0.pwm_cnt_q), sv_pwm);
    check("freeze_presc", 0, int'(dut0.presc_q), sv_presc);
    enable = 1'b1;
    wait_change(0, sv_lvl, 12, lvl);
    check("resume_level", 0, lvl, 192);

    // Saturation with a 200 step.
    snap_off();
    pattern_in = 6'b000001;
    wait_change(1, 0, 12, lvl);
    check("sat_up1", 1, lvl, 200);
    wait_change(1, 200, 12, lvl);
    check("sat_up2", 1, lvl, 255);
    pattern_in = '0;
    wait_change(1, 255, 12, lvl);
    check("sat_dn1", 1, lvl, 55);
    wait_change(1, 55, 12, lvl);
    check("sat_dn2", 1, lvl, 0);

    // Duty cycle over one full PWM period at level 64.
    snap_off();
    pattern_in = 6'b000001;
    wait_change(2, 0, 1100, lvl);
    check("duty_level", 2, lvl, 64);
    highs = 0;
    tick_n(1);
    for (int k = 0; k < 255; k++) begin
      highs += int'(led2[0]);
      tick_n(1);
    end
    check("duty_high_cycles", 2, highs, 64);

    // Reset asserted mid-run clears outputs immediately.
    pattern_in = 6'h3F;
    tick_n(10);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_led", i, get_led(i), 0);
      check("rst_busy", i, get_busy(i), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) check("rst_level", i, get_lvl0(i), 0);
    check("rst_pwm", 0, int'(dut0.pwm_cnt_q), 0);

    // Direct mode and enable vectors.
    for (int v = 0; v < 8; v++) begin
      pattern_in = vecs[v].pat;
      mode       = vecs[v].mode;
      enable     = vecs[v].en;
      tick_n(vecs[v].cyc);
      check("vec_led", v, int'(led0), int'(vecs[v].exp_led));
      check("vec_busy", v, int'(busy0), int'(vecs[v].exp_busy));
    end

    // Random traffic, checked cycle by cycle against the model.
    for (int r = 0; r < 60; r++) begin
      pattern_in = 6'($urandom_range(0, 63));
      mode       = ($urandom_range(0, 7) == 0);
      enable     = ($urandom_range(0, 7) != 0);
      tick_n($urandom_range(1, 12));
    end
    tick_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream stage of the rotating-pattern LED driver. Consumes its 6-bit on/off LED pattern and drives the physical PMOD LED pins.
- Each channel fades smoothly between off and full brightness via PWM, instead of hard switching.
- A direct mode bypasses fading for bring-up.
- Sits between the pattern generator and the top-level LED pads; single clock domain.

Parameters:
- NUM_LEDS, 6: number of LED channels.
- PWM_BITS, 8: brightness resolution; LVL_MAX = 2^PWM_BITS-1.
- STEP_DIV, 65536: clock cycles per fade step (prescaler period); must be ≥ 2.
- FADE_STEP, 8: brightness increment/decrement per step; 1..LVL_MAX.

Ports:
- clk  in  1  system clock (~27 MHz).
- rst  in  1  reset; asynchronous, active-high.
- pattern_in  in  NUM_LEDS  target on/off per channel; same clock domain, sampled every cycle.
- enable  in  1  0 forces outputs off and freezes all counters and levels.
- mode  in  1  0 = fade, 1 = direct (level snaps to target).
- led_out  out  NUM_LEDS  registered PWM outputs to pads.
- busy  out  1  registered; 1 while any channel level ≠ its target.

Behaviour:
- Reset (async, active-high): led_out=0, busy=0, all levels=0, PWM counter=0, prescaler=0, all channel FSMs=OFF.
- PWM counter:
  - Free-running 0..LVL_MAX-1 (period LVL_MAX cycles), wraps to 0.
  - Channel raw output = (pwm_cnt < level).
  - level 0 gives constant low; level LVL_MAX gives constant high.
  - led_out registers raw output, so latency is 1 cycle from counter/level.
- Prescaler:
  - Counts 0..STEP_DIV-1.
  - step_tick=1 for exactly one cycle when the count equals STEP_DIV-1, then wraps to 0.
- Per channel:
  - target = pattern_in[i] ? LVL_MAX : 0.
  - FSM states: OFF (level=0, target 0), RISE, ON (level=LVL_MAX, target max), FALL.
  - OFF→RISE and FALL→RISE when target=LVL_MAX. ON→FALL and RISE→FALL when target=0.
  - A direction reversal mid-fade continues from the current level, with no jump.
  - RISE: on step_tick, level=min(level+FADE_STEP, LVL_MAX). Compute at PWM_BITS+1 width and saturate; never wrap. Enter ON when level reaches LVL_MAX.
  - FALL: on step_tick, level=max(level-FADE_STEP, 0). Saturate at 0, no underflow. Enter OFF when level reaches 0.
  - The level update appears the cycle after the tick cycle.
- Direct mode (mode=1):
  - level=target on the next clk regardless of step_tick.
  - FSM goes straight to ON/OFF.
  - Switching back to fade mode resumes from the current level.
- Pattern toggling faster than a fade is legal. The channel simply reverses; nothing is queued.
- enable=0:
  - led_out=0 on the next cycle.
  - PWM counter, prescaler, levels and FSMs hold their values.
  - On re-enable, operation resumes exactly where it stopped.
  - busy still reflects level≠target.
- busy = OR over channels of (level≠target), registered (1-cycle latency).
- Reset asserted mid-fade: immediate return to reset values; no glitch beyond the async clear of led_out.

Decomposition:
- Shared package led_pkg:
  - LVL_MAX derivation function.
  - Channel state enum: OFF, RISE, ON, FALL.
  - Default PWM_BITS / STEP_DIV constants reused by other LED stages.
- One sub-module led_pwm_channel, instantiated NUM_LEDS times:
  - Inputs: clk, rst, enable, mode, step_tick, pwm_cnt, target_bit.
  - Outputs: led_q, level_ne_target.
- The parent holds the shared PWM counter, prescaler and busy OR.

Test Plan:
- Bench config: PWM_BITS=8, STEP_DIV=4, FADE_STEP=64.
- Reset: assert rst mid-run with pattern_in=6'h3F → led_out=0 and busy=0 immediately; after release, levels start at 0.
- Rise: pattern_in 0→6'b000001 in fade mode → ch0 level steps 64,128,192,255 on four consecutive ticks (16 cycles). busy=1 throughout and drops 1 cycle after 255. Over 255 cycles at level 64, ch0 is high exactly 64 cycles.
- Reversal: rising ch0 at level 128, pattern_in→0 → next ticks give 64, then 0. No jump to 255; state goes RISE→FALL→OFF.
- Direct mode: mode=1, pattern_in=6'h2A → channels 1, 3 and 5 go constant high from the next PWM period; the others stay constant low; no intermediate levels; busy=0 after 2 cycles.
- Enable freeze: enable=0 at ch0 level 128 for 100 cycles → led_out=0; level, PWM counter and prescaler unchanged; re-enable → fade continues to 192 on the next tick.
- Saturation: FADE_STEP=200, rise from 0 → levels 200, then 255 (saturated, no wrap). Fall → 55, then 0.
